// File: rtl/rst_seq_sync.sv
// Reset synchroniser and sequencer: async-assert / sync-release of in_rstn, then a timed,
// in-order release of NUM_CH downstream reset domains, restartable by a software request.
module rst_seq_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_CH      = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4
) (
    input  logic              clk,
    input  logic              in_rstn,
    input  logic              sw_rst_req,
    output logic [NUM_CH-1:0] out_rstn,
    output logic              rst_done
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        ST_RESET,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rstn;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_CH-1:0]      ch_q;
    logic                   done_q;

    // NOTE: every flop here is cleared asynchronously and updated with non-blocking
    // assignments, so all state changes on the same edge see the pre-edge values.
    always_ff @(posedge clk or negedge in_rstn) begin
        if (!in_rstn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_rstn = sync_q[SYNC_STAGES-1];

    // Software request is honoured in every state except RESET, and never reaches sync_q.
    always_ff @(posedge clk or negedge in_rstn) begin
        if (!in_rstn) begin
            state_q <= ST_RESET;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else if (state_q == ST_RESET) begin
            if (sync_rstn) begin
                state_q <= ST_HOLD;
                cnt_q   <= '0;
                idx_q   <= '0;
            end
        end else if (sw_rst_req) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            ch_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        ch_q[0] <= 1'b1;
                        cnt_q   <= '0;
                        idx_q   <= IDX_W'(1);
                        state_q <= (NUM_CH > 1) ? ST_GAP : ST_DONE;
                        done_q  <= (NUM_CH == 1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            if (idx_q == IDX_W'(k)) ch_q[k] <= 1'b1;
                        end
                        cnt_q <= '0;
                        if (idx_q == IDX_LAST) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Assertion follows in_rstn combinationally; release always comes from ch_q.
    assign out_rstn = {NUM_CH{in_rstn}} & ch_q;
    assign rst_done = done_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: a default instance and a minimal-parameter instance share stimulus
// and are compared every cycle against an edge-count model of the release schedule.
module tb_rst_seq_sync;

    localparam int A_S = 2, A_N = 4, A_H = 16, A_G = 4;
    localparam int B_S = 3, B_N = 1, B_H = 1,  B_G = 1;

    logic           clk = 1'b0;
    logic           in_rstn = 1'b1;
    logic           sw_rst_req = 1'b0;
    logic [A_N-1:0] out_a;
    logic           done_a;
    logic [B_N-1:0] out_b;
    logic           done_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: edges since in_rstn release, and the edge at which the current sequence started.
    int e_a = 0, st_a = -1, e_b = 0, st_b = -1;
    int ma, mb;

    always #5 clk = ~clk;

    rst_seq_sync #(.SYNC_STAGES(A_S), .NUM_CH(A_N), .HOLD_CYCLES(A_H), .GAP_CYCLES(A_G)) dut_a (
        .clk       (clk),
        .in_rstn   (in_rstn),
        .sw_rst_req(sw_rst_req),
        .out_rstn  (out_a),
        .rst_done  (done_a)
    );

    rst_seq_sync #(.SYNC_STAGES(B_S), .NUM_CH(B_N), .HOLD_CYCLES(B_H), .GAP_CYCLES(B_G)) dut_b (
        .clk       (clk),
        .in_rstn   (in_rstn),
        .sw_rst_req(sw_rst_req),
        .out_rstn  (out_b),
        .rst_done  (done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Channel k is free once HOLD + k*GAP edges have elapsed since the sequence started.
    function automatic int exp_mask(input int e, input int st, input int n, input int h, input int g);
        int m = 0;
        if (st >= 0) begin
            for (int k = 0; k < n; k++) begin
                if (e - st >= h + k * g) m |= (1 << k);
            end
        end
        return m;
    endfunction

    always @(posedge clk) begin
        if (in_rstn) begin
            e_a <= e_a + 1;
            if (e_a + 1 == A_S + 1 || (e_a + 1 > A_S + 1 && sw_rst_req)) st_a <= e_a + 1;
            e_b <= e_b + 1;
            if (e_b + 1 == B_S + 1 || (e_b + 1 > B_S + 1 && sw_rst_req)) st_b <= e_b + 1;
        end
    end

    always @(negedge in_rstn) begin
        e_a  <= 0;
        st_a <= -1;
        e_b  <= 0;
        st_b <= -1;
    end

    always @(posedge clk) begin
        #2;
        ma = in_rstn ? exp_mask(e_a, st_a, A_N, A_H, A_G) : 0;
        mb = in_rstn ? exp_mask(e_b, st_b, B_N, B_H, B_G) : 0;
        check("model_out_a",  32'(out_a),  32'(ma));
        check("model_done_a", 32'(done_a), 32'((ma >> (A_N - 1)) & 1));
        check("model_out_b",  32'(out_b),  32'(mb));
        check("model_done_b", 32'(done_b), 32'((mb >> (B_N - 1)) & 1));
    end

    // Advance n rising edges and settle 3 time units past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic restart_seq();
        in_rstn = 1'b0;
        step(2);
        in_rstn = 1'b1;
    endtask

    initial begin
        int r;
        #1 in_rstn = 1'b0;

        // Power-on
        step(5);
        check("por_out_a", 32'(out_a), 32'h0);
        check("por_done_a", 32'(done_a), 32'h0);
        in_rstn = 1'b1;
        step(4);
        check("sweep_e4_out", 32'(out_b), 32'h0);
        step(1);
        check("sweep_e5_out", 32'(out_b), 32'h1);
        check("sweep_e5_done", 32'(done_b), 32'h1);
        step(13);
        check("por_e18", 32'(out_a), 32'h0);
        step(1);
        check("por_e19", 32'(out_a), 32'h1);
        step(4);
        check("por_e23", 32'(out_a), 32'h3);
        step(4);
        check("por_e27", 32'(out_a), 32'h7);
        check("por_e27_done", 32'(done_a), 32'h0);
        step(4);
        check("por_e31", 32'(out_a), 32'hf);
        check("por_e31_done", 32'(done_a), 32'h1);

        // Async assertion between edges while in DONE
        step(3);
        #2 in_rstn = 1'b0;
        #1;
        check("async_out_a", 32'(out_a), 32'h0);
        check("async_done_a", 32'(done_a), 32'h0);
        check("async_out_b", 32'(out_b), 32'h0);
        #1 in_rstn = 1'b1;
        step(18);
        check("async_e18", 32'(out_a), 32'h0);
        step(1);
        check("async_e19", 32'(out_a), 32'h1);
        step(12);
        check("async_e31", 32'(out_a), 32'hf);
        check("async_e31_done", 32'(done_a), 32'h1);

        // Software reset sampled at E40 while in DONE
        step(8);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("sw_e40_out", 32'(out_a), 32'h0);
        check("sw_e40_done", 32'(done_a), 32'h0);
        step(15);
        check("sw_e55", 32'(out_a), 32'h0);
        step(1);
        check("sw_e56", 32'(out_a), 32'h1);
        step(4);
        check("sw_e60", 32'(out_a), 32'h3);
        step(8);
        check("sw_e68", 32'(out_a), 32'hf);
        check("sw_e68_done", 32'(done_a), 32'h1);

        // Software reset mid-sequence, single pulse at E25
        restart_seq();
        step(24);
        check("mid_e24", 32'(out_a), 32'h3);
        sw_rst_req = 1'b1;
        step(1);
        sw_rst_req = 1'b0;
        check("mid_e25", 32'(out_a), 32'h0);
        step(15);
        check("mid_e40", 32'(out_a), 32'h0);
        step(1);
        check("mid_e41", 32'(out_a), 32'h1);

        // Software reset held for E25..E30
        restart_seq();
        step(24);
        sw_rst_req = 1'b1;
        step(6);
        sw_rst_req = 1'b0;
        check("held_e30", 32'(out_a), 32'h0);
        step(15);
        check("held_e45", 32'(out_a), 32'h0);
        step(1);
        check("held_e46", 32'(out_a), 32'h1);

        // Request held through in_rstn low and release, dropped after E30
        sw_rst_req = 1'b1;
        in_rstn = 1'b0;
        step(3);
        in_rstn = 1'b1;
        step(30);
        check("swhold_e30_a", 32'(out_a), 32'h0);
        check("swhold_e30_b", 32'(out_b), 32'h0);
        sw_rst_req = 1'b0;
        step(1);
        check("swhold_e31_b", 32'(out_b), 32'h1);
        step(14);
        check("swhold_e45_a", 32'(out_a), 32'h0);
        step(1);
        check("swhold_e46_a", 32'(out_a), 32'h1);

        // Randomised requests, glitches and longer resets against the model
        for (int i = 0; i < 3000; i++) begin
            step(1);
            sw_rst_req = ($urandom_range(0, 79) == 0);
            r = $urandom_range(0, 199);
            if (r == 0) begin
                #($urandom_range(0, 3));
                in_rstn = 1'b0;
                #1;
                check("rnd_glitch_out_a", 32'(out_a), 32'h0);
                check("rnd_glitch_done_a", 32'(done_a), 32'h0);
                #($urandom_range(1, 2));
                in_rstn = 1'b1;
            end else if (r == 1) begin
                in_rstn = 1'b0;
                step($urandom_range(1, 3));
                in_rstn = 1'b1;
            end
        end
        sw_rst_req = 1'b0;
        step(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq_sync.md
# rst_seq_sync

Parametrised reset synchroniser and sequencer: an asynchronous active-low reset is asserted immediately and released synchronously through a configurable-depth synchroniser. The block then holds reset for a minimum width and releases NUM_CH downstream reset domains one at a time, in order, with a fixed gap between releases. A synchronous software reset request restarts the sequence without disturbing the synchroniser. It sits at the top of each clock domain and feeds the core, bus fabric and peripheral resets.

## Interface
- SYNC_STAGES, 2: synchroniser flop depth; legal range ≥2.
- NUM_CH, 4: number of sequenced reset outputs; legal range ≥1.
- HOLD_CYCLES, 16: cycles from sequence start to channel 0 release; legal range ≥1.
- GAP_CYCLES, 4: cycles between channel k and channel k+1 release; legal range ≥1.
- clk  input  1  clock.
- in_rstn  input  1  reset, asynchronous, active-low.
- sw_rst_req  input  1  synchronous software reset request, level-sampled on every clk rising edge.
- out_rstn  output  NUM_CH  per-channel reset, active-low; bit 0 is released first.
- rst_done  output  1  high when all channels have been released.

## Operation
- Synchroniser: SYNC_STAGES flops, all asynchronously cleared by in_rstn low. The first stage shifts in 1; its output is sync_rstn.
- FSM states:
  - RESET: entered asynchronously whenever in_rstn is low; stays while sync_rstn=0. RESET→HOLD on the edge where sync_rstn=1; the counter is cleared.
  - HOLD: counts HOLD_CYCLES. On the count's last edge, set ch_q[0]; go to GAP if NUM_CH>1, otherwise go to DONE.
  - GAP: counts GAP_CYCLES per channel. On the last edge of each count, set ch_q[idx]; go to DONE after ch_q[NUM_CH-1] is set.
  - DONE: rst_done=1; the block idles here.
- out_rstn[k] = in_rstn & ch_q[k]. Assertion is combinational from in_rstn with no clock required; release is always from a flop.
- rst_done is registered and is set on the same edge as ch_q[NUM_CH-1].
- Software reset:
  - If sw_rst_req=1 at an edge while in HOLD, GAP or DONE, then on that edge all ch_q clear, rst_done clears, the state becomes HOLD and the counters restart.
  - If sw_rst_req is held high, the block stays in HOLD with all channels in reset.
  - sw_rst_req is ignored in RESET.
  - sw_rst_req never touches the synchroniser.
- Counter width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). The channel index width is $clog2(NUM_CH) (minimum 1). Counters never wrap, because they are reloaded on every state entry.
- Reset values (in_rstn low): out_rstn=0 on all bits, rst_done=0, state=RESET, all synchroniser flops=0, counters=0.

## Timing
- Let E1 be the first clk rising edge after in_rstn deasserts.
- sync_rstn rises at E_S, where S=SYNC_STAGES. HOLD is entered at E_{S+1}.
- out_rstn[k] rises at E_{S+1+HOLD_CYCLES+k·GAP_CYCLES}. rst_done rises at the same edge as out_rstn[NUM_CH-1].
- Defaults: ch0 at E19, ch1 at E23, ch2 at E27, ch3 and rst_done at E31.
- Software reset sampled at edge Ex: out_rstn clears after Ex (clock-to-q). ch k releases at E_{x+HOLD_CYCLES+k·GAP_CYCLES}.
- in_rstn low mid-sequence, including a glitch shorter than one cycle: all outputs go low immediately, and the full sequence restarts from E1 of the next deassertion.
- in_rstn deasserting within setup/hold of an edge: release may slip by one cycle. Relative channel spacing is unchanged.
- Once DONE is reached, no output toggles until in_rstn goes low or sw_rst_req goes high.

## Test plan
- Power-on with defaults: in_rstn low for 5 cycles, then high → out_rstn=4'b0000 until E19. Then 0001@E19, 0011@E23, 0111@E27, 1111@E31; rst_done=1@E31.
- Async assert: in_rstn pulled low between edges while in DONE → out_rstn=0000 and rst_done=0 with no clock edge. On release, the E19/E23/E27/E31 sequence repeats.
- Software reset: one-cycle sw_rst_req at edge Ex=E40 in DONE → out_rstn=0000 after E40. Then 0001@E56, 0011@E60, 0111@E64, 1111@E68.
- Software reset mid-sequence: sw_rst_req at E25 (state GAP, out=0011) → out=0000 after E25, ch0 released @E41. With sw_rst_req held high for E25..E30, ch0 releases @E46.
- Parameter sweep: SYNC_STAGES=3, NUM_CH=1, HOLD_CYCLES=1, GAP_CYCLES=1 → out_rstn[0] and rst_done rise at E5.
- sw_rst_req=1 held throughout in_rstn low and through release → the synchroniser is unaffected. The block is held in HOLD with all channels in reset while the request stays high. Once sw_rst_req drops, ch0 releases HOLD_CYCLES edges after the last edge at which the request was sampled high.
